register_file_2r1w: RTL and testbench



---
 rtl/register_file_2r1w.sv | 86 ++++++++
 tb/tb_register_file_2r1w.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// 32 x 32-bit register file with one synchronous write port and two registered read ports.
// READ and WRITE are mutually exclusive per edge; asserting both is treated as idle.
module register_file_2r1w #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] ADDR_R1,
   input  logic [ADDR_WIDTH-1:0] ADDR_R2,
   input  logic [ADDR_WIDTH-1:0] ADDR_W,
   input  logic [DATA_WIDTH-1:0] DATA_W,
   input  logic                  READ,
   input  logic                  WRITE,
   output logic [DATA_WIDTH-1:0] DATA_R1,
   output logic [DATA_WIDTH-1:0] DATA_R2
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
   logic [DEPTH-1:0]      wrSel;
   logic                  writeEn;
   logic                  readEn;

   assign writeEn = WRITE & ~READ;
   assign readEn  = READ & ~WRITE;

   // One-hot write decode; entry 0 is never selected when it is hardwired to zero.
   always_comb begin
      wrSel = '0;
      if (writeEn) begin
         wrSel[ADDR_W] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         wrSel[0] = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wrSel[i]) begin
               mem_q[i] <= DATA_W;
            end
         end
      end
   end

   // Read selects feed the output registers; outputs only move on a legal read edge.
   always_comb begin
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      if (readEn) begin
         rdata1_d = mem_q[ADDR_R1];
         rdata2_d = mem_q[ADDR_R2];
         if (ZERO_REG != 0 && ADDR_R1 == '0) begin
            rdata1_d = '0;
         end
         if (ZERO_REG != 0 && ADDR_R2 == '0) begin
            rdata2_d = '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdata1_q <= '0;
         rdata2_q <= '0;
      end else begin
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
      end
   end

   assign DATA_R1 = rdata1_q;
   assign DATA_R2 = rdata2_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w: vector tables, hand-written corner
// sequences and a randomized phase checked against an array-based reference model.
module tb_register_file_2r1w;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [4:0]  aw;
      logic [31:0] dw;
      logic [31:0] e1;
      logic [31:0] e2;
      string       name;
   } vec_t;

   logic        CLK;
   logic        RST;
   logic [4:0]  ADDR_R1;
   logic [4:0]  ADDR_R2;
   logic [4:0]  ADDR_W;
   logic [31:0] DATA_W;
   logic        READ;
   logic        WRITE;
   logic [31:0] DATA_R1;
   logic [31:0] DATA_R2;

   int compared = 0;
   int mismatched = 0;

   // Reference state: plain arrays updated from the behavioural rules.
   logic [31:0] refMem [32];
   logic [31:0] refOut1;
   logic [31:0] refOut2;

   vec_t tbl[$];

   register_file_2r1w #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5),
      .ZERO_REG(1)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .ADDR_R1(ADDR_R1),
      .ADDR_R2(ADDR_R2),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .READ(READ),
      .WRITE(WRITE),
      .DATA_R1(DATA_R1),
      .DATA_R2(DATA_R2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      mismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one vector on the falling edge, then check both outputs just after the rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge CLK);
      READ    = v.rd;
      WRITE   = v.wr;
      ADDR_R1 = v.a1;
      ADDR_R2 = v.a2;
      ADDR_W  = v.aw;
      DATA_W  = v.dw;
      @(posedge CLK);
      #1;
      checkOutput({v.name, "_r1"}, DATA_R1, v.e1);
      checkOutput({v.name, "_r2"}, DATA_R2, v.e2);
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] aw, input logic [31:0] dw,
                               input logic [31:0] e1, input logic [31:0] e2, input string name);
      vec_t v;
      v.rd = rd; v.wr = wr; v.a1 = a1; v.a2 = a2; v.aw = aw; v.dw = dw;
      v.e1 = e1; v.e2 = e2; v.name = name;
      return v;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 32; i++) refMem[i] = 32'h0;
      refOut1 = 32'h0;
      refOut2 = 32'h0;
   endtask

   // Build a vector whose expectation comes from advancing the reference model.
   function automatic vec_t modelStep(input logic rd, input logic wr, input logic [4:0] a1,
                                      input logic [4:0] a2, input logic [4:0] aw,
                                      input logic [31:0] dw, input string name);
      if (rd && !wr) begin
         refOut1 = (a1 == 0) ? 32'h0 : refMem[a1];
         refOut2 = (a2 == 0) ? 32'h0 : refMem[a2];
      end else if (wr && !rd && aw != 0) begin
         refMem[aw] = dw;
      end
      return mk(rd, wr, a1, a2, aw, dw, refOut1, refOut2, name);
   endfunction

   task automatic pulseReset();
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      modelReset();
   endtask

   initial begin
      logic [31:0] old1;
      RST = 1'b0; READ = 1'b0; WRITE = 1'b1;
      ADDR_R1 = '0; ADDR_R2 = '0; ADDR_W = '0; DATA_W = '0;
      modelReset();

      // Reset held low while writes are attempted.
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         ADDR_W = 5'(i + 3);
         DATA_W = $urandom;
         @(posedge CLK);
         #1;
         checkOutput($sformatf("reset_hold%0d_r1", i), DATA_R1, 32'h0);
         checkOutput($sformatf("reset_hold%0d_r2", i), DATA_R2, 32'h0);
      end
      @(negedge CLK);
      RST = 1'b1;
      WRITE = 1'b0;
      applyStimulus(mk(1, 0, 5, 31, 0, 0, 32'h0, 32'h0, "reset_read"));

      // Fill/readback table.
      for (int i = 1; i < 32; i++)
         tbl.push_back(mk(0, 1, 0, 0, 5'(i), 32'h1000_0000 + i, 32'h0, 32'h0,
                          $sformatf("fill_w%0d", i)));
      for (int i = 1; i < 32; i++)
         tbl.push_back(mk(1, 0, 5'(i), 5'(32 - i), 0, 0, 32'h1000_0000 + i,
                          32'h1000_0000 + (32 - i), $sformatf("fill_r%0d", i)));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0, 32'h1000_0001, "read_r0"));
      // Zero register discards writes.
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0, 32'h1000_0001, "zero_w"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, "zero_r"));
      // Hold and illegal READ+WRITE.
      tbl.push_back(mk(0, 1, 0, 0, 7, 32'hA5A5_A5A5, 32'h0, 32'h0, "hold_w7"));
      tbl.push_back(mk(1, 0, 7, 7, 0, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "hold_r7"));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 0, 1, 2, 3, 32'h1234_5678, 32'hA5A5_A5A5, 32'hA5A5_A5A5,
                          $sformatf("idle%0d", i)));
      tbl.push_back(mk(1, 1, 1, 2, 7, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "illegal"));
      tbl.push_back(mk(1, 0, 7, 1, 0, 0, 32'hA5A5_A5A5, 32'h1000_0001, "after_illegal"));

      foreach (tbl[k]) applyStimulus(tbl[k]);

      // Async reset between edges clears the output before the next clock.
      applyStimulus(mk(0, 1, 0, 0, 3, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h1000_0001, "async_w3"));
      applyStimulus(mk(1, 0, 3, 3, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "async_r3"));
      @(posedge CLK);
      #2;
      RST = 1'b0;
      #1;
      checkOutput("async_mid_r1", DATA_R1, 32'h0);
      checkOutput("async_mid_r2", DATA_R2, 32'h0);
      #1;
      RST = 1'b1;
      applyStimulus(mk(1, 0, 3, 7, 0, 0, 32'h0, 32'h0, "async_reread"));

      // Write on edge n, read on edge n+1.
      applyStimulus(mk(0, 1, 0, 0, 10, 32'h0BAD_F00D, 32'h0, 32'h0, "order_w10"));
      applyStimulus(mk(1, 0, 10, 10, 0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, "order_r10"));
      old1 = 32'h0BAD_F00D;
      applyStimulus(mk(0, 1, 9, 9, 9, 32'h0000_0009, old1, old1, "order_w9"));
      applyStimulus(mk(1, 0, 9, 10, 0, 0, 32'h0000_0009, 32'h0BAD_F00D, "order_r9"));

      // Randomized phase against the reference model.
      pulseReset();
      for (int i = 0; i < 400; i++) begin
         logic [1:0] op;
         logic [4:0] a1, a2, aw;
         logic [31:0] dw;
         op = 2'($urandom_range(0, 3));
         a1 = 5'($urandom);
         a2 = (($urandom & 3) == 0) ? a1 : 5'($urandom);
         aw = 5'($urandom);
         dw = $urandom;
         applyStimulus(modelStep(op[1] | (op == 2'b01 && i[0]), op[0], a1, a2, aw, dw,
                                 $sformatf("rand%0d", i)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
